// File: rtl/cfi_mbox_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cfi_mbox_arbiter_if
//  Description : Bundle of the per-hart log-queue side and the mailbox
//                backend side of the CFI mailbox arbiter. The master modport
//                is the arbiter's view; the slave modport is the view of the
//                queues and backend that surround it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cfi_mbox_arbiter_if #(
    parameter int NR_REQ = 4,
    parameter int LOG_W  = 128
);
    localparam int c_SRC_W = $clog2(NR_REQ);

    // Queue side
    logic                      enable_i;
    logic [NR_REQ-1:0]         req_valid_i;
    logic [NR_REQ*LOG_W-1:0]   req_log_i;
    logic [NR_REQ-1:0]         req_pop_o;

    // Backend side
    logic                      be_valid_o;
    logic                      be_ready_i;
    logic [LOG_W-1:0]          be_log_o;
    logic [c_SRC_W-1:0]        be_src_o;
    logic                      be_done_i;
    logic                      be_abort_o;

    // Status
    logic [NR_REQ-1:0]         grant_o;
    logic                      busy_o;
    logic [15:0]               timeout_cnt_o;

    modport master (
        input  enable_i, req_valid_i, req_log_i, be_ready_i, be_done_i,
        output req_pop_o, be_valid_o, be_log_o, be_src_o, be_abort_o,
               grant_o, busy_o, timeout_cnt_o
    );

    modport slave (
        output enable_i, req_valid_i, req_log_i, be_ready_i, be_done_i,
        input  req_pop_o, be_valid_o, be_log_o, be_src_o, be_abort_o,
               grant_o, busy_o, timeout_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/cfi_mbox_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cfi_mbox_arbiter
//  Description : Round-robin arbiter sharing one CFI mailbox backend between
//                NR_REQ per-hart log queues. Latches the granted queue's head
//                log, offers it to the backend, waits for completion or a
//                timeout, then pops the served queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfi_mbox_arbiter #(
    parameter int NR_REQ         = 4,
    parameter int LOG_W          = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    cfi_mbox_arbiter_if.master  bus
);

    localparam int c_SRC_W = $clog2(NR_REQ);
    localparam int c_IDX_W = c_SRC_W + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_SRC_W-1:0] c_SRC_LAST = c_SRC_W'(NR_REQ - 1);
    localparam logic [NR_REQ-1:0]  c_ONE_HOT0 = NR_REQ'(1);
    localparam logic [15:0]        c_CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RELEASE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_SRC_W-1:0]   r_rr_ptr;
    logic [c_SRC_W-1:0]   w_rr_ptr_nxt;
    logic [c_SRC_W-1:0]   r_be_src;
    logic [c_SRC_W-1:0]   w_be_src_nxt;
    logic [NR_REQ-1:0]    r_grant;
    logic [NR_REQ-1:0]    w_grant_nxt;
    logic [LOG_W-1:0]     r_be_log;
    logic [LOG_W-1:0]     w_be_log_nxt;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_TMR_W-1:0]   w_timer_nxt;
    logic [15:0]          r_timeout_cnt;
    logic [15:0]          w_timeout_cnt_nxt;

    logic                 w_be_valid;
    logic                 w_be_abort;
    logic [NR_REQ-1:0]    w_req_pop;

    logic                 w_found;
    logic [c_SRC_W-1:0]   w_pick;
    logic [c_IDX_W-1:0]   w_idx;

    // Round-robin pick: scan offsets high to low so the smallest offset from
    // the pointer that has a valid request is the one left in w_pick.
    always_comb begin : p_rr_pick
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
            if (w_idx >= c_IDX_W'(NR_REQ)) begin
                w_idx = w_idx - c_IDX_W'(NR_REQ);
            end
            if (bus.req_valid_i[w_idx[c_SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[c_SRC_W-1:0];
            end
        end
    end

    // Next-state and output decode; every register holds unless a state acts.
    always_comb begin : p_fsm_comb
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_be_src_nxt      = r_be_src;
        w_grant_nxt       = r_grant;
        w_be_log_nxt      = r_be_log;
        w_timer_nxt       = r_timer;
        w_timeout_cnt_nxt = r_timeout_cnt;
        w_be_valid        = 1'b0;
        w_be_abort        = 1'b0;
        w_req_pop         = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.enable_i && w_found) begin
                    w_be_src_nxt = w_pick;
                    w_grant_nxt  = c_ONE_HOT0 << w_pick;
                    w_be_log_nxt = bus.req_log_i[int'(w_pick) * LOG_W +: LOG_W];
                    w_state_nxt  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Offer stays up until the backend takes it; no timeout here.
                w_be_valid = 1'b1;
                if (bus.be_ready_i) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                // Completion takes priority over a timeout in the same cycle.
                if (bus.be_done_i) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_timer == c_TMR_LAST) begin
                    w_be_abort  = 1'b1;
                    if (r_timeout_cnt != c_CNT_MAX) begin
                        w_timeout_cnt_nxt = r_timeout_cnt + 16'd1;
                    end
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end

            S_RELEASE: begin
                // The served entry is popped whether it completed or timed out.
                w_req_pop    = r_grant;
                w_rr_ptr_nxt = (r_be_src == c_SRC_LAST) ? '0 : r_be_src + c_SRC_W'(1);
                w_grant_nxt  = '0;
                w_state_nxt  = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin : p_state_reg
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, latched log, round-robin pointer, timer and timeout counter.
    always_ff @(posedge clk_i) begin : p_data_reg
        if (rst_i) begin
            r_rr_ptr      <= '0;
            r_be_src      <= '0;
            r_grant       <= '0;
            r_be_log      <= '0;
            r_timer       <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_be_src      <= w_be_src_nxt;
            r_grant       <= w_grant_nxt;
            r_be_log      <= w_be_log_nxt;
            r_timer       <= w_timer_nxt;
            r_timeout_cnt <= w_timeout_cnt_nxt;
        end
    end

    assign bus.req_pop_o     = w_req_pop;
    assign bus.be_valid_o    = w_be_valid;
    assign bus.be_log_o      = r_be_log;
    assign bus.be_src_o      = r_be_src;
    assign bus.be_abort_o    = w_be_abort;
    assign bus.grant_o       = r_grant;
    assign bus.busy_o        = (r_state != S_IDLE);
    assign bus.timeout_cnt_o = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cfi_mbox_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfi_mbox_arbiter
//  Description : Self-checking bench for cfi_mbox_arbiter: a directed vector
//                table, hand-written corner sequences and a randomized run
//                compared every cycle against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfi_mbox_arbiter;

    localparam int NR = 4;
    localparam int LW = 128;
    localparam int TO = 16;

    localparam int PH_IDLE  = 0;   // no transfer in progress
    localparam int PH_OFFER = 1;   // log offered, backend not yet taken it
    localparam int PH_WAIT  = 2;   // backend owns the log
    localparam int PH_POP   = 3;   // popping the served queue

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cfi_mbox_arbiter_if #(.NR_REQ(NR), .LOG_W(LW)) bus ();

    cfi_mbox_arbiter #(
        .NR_REQ         (NR),
        .LOG_W          (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [LW-1:0] logs [NR];

    always_comb begin
        bus.req_log_i = '0;
        for (int i = 0; i < NR; i++) bus.req_log_i[i*LW +: LW] = logs[i];
    end

    // Reference model state
    int            m_ph;
    int            m_src;
    int            m_ptr;
    int            m_wait;
    int            m_tcnt;
    logic [LW-1:0] m_log;

    // Sampled DUT outputs of the current cycle
    logic          s_busy, s_valid, s_abort;
    logic [NR-1:0] s_grant, s_pop;
    logic [1:0]    s_src;
    logic [LW-1:0] s_log;
    logic [15:0]   s_tcnt;

    typedef struct {
        logic          en;
        logic [NR-1:0] v;
        logic          rd;
        logic          dn;
        logic          busy;
        logic          bv;
        int            src;
        logic [NR-1:0] gnt;
        logic [NR-1:0] pop;
        int            lsel;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [LW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_src = 0; m_ptr = 0; m_wait = 0; m_tcnt = 0; m_log = '0;
    endtask

    // Advance the model by the clock edge that commits these inputs.
    task automatic model_step(input logic r, input logic e, input logic [NR-1:0] v,
                              input logic rd, input logic dn);
        bit found;
        int idx;
        if (r) begin
            model_reset();
        end else if (m_ph == PH_IDLE) begin
            found = 0;
            if (e) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (!found && v[idx]) begin
                        found = 1;
                        m_src = idx;
                        m_log = logs[idx];
                        m_ph  = PH_OFFER;
                    end
                end
            end
        end else if (m_ph == PH_OFFER) begin
            if (rd) begin
                m_ph = PH_WAIT;
                m_wait = 0;
            end
        end else if (m_ph == PH_WAIT) begin
            if (dn) begin
                m_ph = PH_POP;
            end else if (m_wait == TO - 1) begin
                if (m_tcnt < 65535) m_tcnt++;
                m_ph = PH_POP;
            end else begin
                m_wait++;
            end
        end else begin
            m_ptr = (m_src + 1) % NR;
            m_ph  = PH_IDLE;
        end
    endtask

    // One clock cycle: drive after the edge, sample mid-cycle, compare, update model.
    task automatic cycle(input logic r, input logic e, input logic [NR-1:0] v,
                         input logic rd, input logic dn, input bit rl);
        logic [28:0]   act_v, exp_v;
        logic [NR-1:0] e_g, e_p;
        logic          e_ab;
        @(posedge clk);
        #1;
        rst = r;
        bus.enable_i    = e;
        bus.req_valid_i = v;
        bus.be_ready_i  = rd;
        bus.be_done_i   = dn;
        if (rl) for (int i = 0; i < NR; i++) logs[i] = rand128();
        @(negedge clk);
        s_busy  = bus.busy_o;
        s_valid = bus.be_valid_o;
        s_abort = bus.be_abort_o;
        s_grant = bus.grant_o;
        s_pop   = bus.req_pop_o;
        s_src   = bus.be_src_o;
        s_log   = bus.be_log_o;
        s_tcnt  = bus.timeout_cnt_o;
        e_g  = (m_ph != PH_IDLE) ? (NR'(1) << m_src) : '0;
        e_p  = (m_ph == PH_POP)  ? (NR'(1) << m_src) : '0;
        e_ab = (m_ph == PH_WAIT) && (m_wait == TO - 1) && !dn;
        act_v = {s_busy, s_valid, s_grant, s_pop, s_abort, s_src, s_tcnt};
        exp_v = {m_ph != PH_IDLE, m_ph == PH_OFFER, e_g, e_p, e_ab, 2'(m_src), 16'(m_tcnt)};
        chk("model_busy_valid_grant_pop_abort_src_tcnt", LW'(act_v), LW'(exp_v));
        chk("model_be_log", s_log, m_log);
        chk("grant_onehot0", LW'($onehot0(s_grant)), LW'(1));
        chk("pop_onehot0", LW'($onehot0(s_pop)), LW'(1));
        model_step(r, e, v, rd, dn);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int popc[NR];
        logic [LW-1:0] exp_log;
        logic [LW-1:0] tlog;

        rst = 1'b1;
        bus.enable_i = 1'b0; bus.req_valid_i = '0; bus.be_ready_i = 1'b0; bus.be_done_i = 1'b0;
        for (int i = 0; i < NR; i++) logs[i] = {4{32'hA5A5_0000 + 32'(i)}};
        repeat (2) @(posedge clk);
        model_reset();

        // Directed vectors: single request on queue 2, then wrap-around 3 before 1
        tbl[0]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, -1};
        tbl[1]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 2, 4'b0100, 4'b0000,  2};
        tbl[2]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2, 4'b0100, 4'b0000,  2};
        tbl[3]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2, 4'b0100, 4'b0000,  2};
        tbl[4]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2, 4'b0100, 4'b0000,  2};
        tbl[5]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2, 4'b0100, 4'b0000,  2};
        tbl[6]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b0100, 4'b0000,  2};
        tbl[7]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2, 4'b0100, 4'b0100,  2};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 4'b0000,  2};
        tbl[9]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 4'b0000,  2};
        tbl[10] = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b1, 3, 4'b1000, 4'b0000,  3};
        tbl[11] = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 3, 4'b1000, 4'b0000,  3};
        tbl[12] = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 3, 4'b1000, 4'b1000,  3};
        tbl[13] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 3, 4'b0000, 4'b0000,  3};
        tbl[14] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1, 4'b0010, 4'b0000,  1};
        tbl[15] = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1, 4'b0010, 4'b0000,  1};
        tbl[16] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1, 4'b0010, 4'b0010,  1};
        tbl[17] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4'b0000, 4'b0000,  1};

        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, tbl[i].en, tbl[i].v, tbl[i].rd, tbl[i].dn, 1'b0);
            chk($sformatf("vec%0d_busy_valid_grant_pop_src", i),
                LW'({s_busy, s_valid, s_grant, s_pop, s_src}),
                LW'({tbl[i].busy, tbl[i].bv, tbl[i].gnt, tbl[i].pop, 2'(tbl[i].src)}));
            if (tbl[i].lsel < 0) tlog = '0;
            else                 tlog = logs[tbl[i].lsel];
            chk($sformatf("vec%0d_be_log", i), s_log, tlog);
        end

        // All queues valid with instant ready/done: grants 0,1,2,3,0
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int q = 0; q < NR; q++) popc[q] = 0;
        for (int c = 0; c < 24 && order.size() < 5; c++) begin
            cycle(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);
            if (s_valid) order.push_back(int'(s_src));
            if (c < 16) for (int q = 0; q < NR; q++) if (s_pop[q]) popc[q]++;
        end
        chk("rr_grant_count", LW'(order.size()), LW'(5));
        for (int i = 0; i < 5; i++)
            if (i < order.size()) chk($sformatf("rr_order%0d", i), LW'(order[i]), LW'(i % NR));
        for (int q = 0; q < NR; q++) chk($sformatf("rr_pops_q%0d", q), LW'(popc[q]), LW'(1));

        // Timeout: abort on the last waiting cycle, pop follows, counter steps
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= TO; n++) begin
            cycle(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
            chk($sformatf("timeout_abort_cyc%0d", n), LW'(s_abort), LW'(n == TO));
        end
        cycle(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("timeout_pop", LW'(s_pop), LW'(4'b0001));
        chk("timeout_cnt", LW'(s_tcnt), LW'(1));

        // Done coincident with timeout: done wins, no abort, count unchanged
        cycle(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= TO; n++) begin
            cycle(1'b0, 1'b1, 4'b0001, 1'b1, n == TO, 1'b0);
            if (n == TO) chk("coincident_abort", LW'(s_abort), LW'(0));
        end
        cycle(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("coincident_pop", LW'(s_pop), LW'(4'b0001));
        chk("coincident_cnt", LW'(s_tcnt), LW'(1));

        // Reset while waiting for done, then enable low with pending requests
        cycle(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("rst_outputs_zero",
            LW'({s_busy, s_valid, s_abort, s_grant, s_pop, s_src, s_tcnt}), LW'(0));
        chk("rst_be_log_zero", s_log, '0);
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
            chk($sformatf("disabled_idle%0d", n), LW'({s_busy, s_grant}), LW'(0));
        end

        // Backend stalls while queue heads change: offer and log stay put
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        exp_log = logs[2];
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
            chk($sformatf("stall_valid%0d", n), LW'(s_valid), LW'(1));
            chk($sformatf("stall_log%0d", n), s_log, exp_log);
        end
        cycle(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("stall_pop", LW'(s_pop), LW'(4'b0100));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 150) == 0, ($urandom % 10) != 0, NR'($urandom),
                  1'($urandom % 2),
                  (n < 1500) ? (($urandom % 4) == 0) : (($urandom % 40) == 0),
                  1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
